// File: rtl/risc_pkg.sv
// Shared pipeline definitions used by fetch and decode.
package risc_pkg;

    // Encoding that decode treats as a no-operation bubble.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Default address fetched first after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch controller states:
    //   S_WAIT - request for pc_q is (or is about to be) outstanding
    //   S_DROP - request outstanding but its data is stale after a redirect
    //   S_FULL - a fetched word is parked in the skid buffer, no request
    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_DROP = 2'd1,
        S_FULL = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched instruction word and its address
// while decode is stalled.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        full
);

    logic        full_q, full_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q,   pc_d;

    // Next-state: clear/unload empty the entry and win over a load.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        full_d = full_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (clear || unload) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = load_data;
            pc_d   = load_pc;
        end
    end

    // Occupancy flag is the only state that must be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; it is never observed unless full_q is set.
        data_q <= data_d;
        pc_q   <= pc_d;
    end

    assign data = data_q;
    assign pc   = pc_q;
    assign full = full_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches over a req/ack
// handshake, absorbs decode stalls in a one-entry skid buffer and flushes
// on redirects from the branch logic.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = risc_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = risc_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC_1,
    output logic        if_valid
);

    import risc_pkg::*;

    if_state_t   state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] pc_pending_q, pc_pending_d;
    logic [31:0] ir_q,         ir_d;
    logic [31:0] pc_1_q,       pc_1_d;
    logic        if_valid_q,   if_valid_d;

    logic        skid_load;
    logic        skid_unload;
    logic        skid_clear;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;
    logic        skid_full;

    if_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_data (imem_rdata),
        .load_pc   (pc_q),
        .data      (skid_data),
        .pc        (skid_pc),
        .full      (skid_full)
    );

    // Next-state logic; redirect beats stall beats normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_pending_d = pc_pending_q;
        ir_d         = ir_q;
        pc_1_d       = pc_1_q;
        if_valid_d   = if_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d       = redirect_pc;
                        ir_d       = NOP_INSTR;
                        if_valid_d = 1'b0;
                    end else if (stall) begin
                        skid_load  = 1'b1;
                        pc_d       = pc_q + 32'd1;
                        state_d    = S_FULL;
                    end else begin
                        ir_d       = imem_rdata;
                        pc_1_d     = pc_q + 32'd1;
                        pc_d       = pc_q + 32'd1;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    if (redirect) begin
                        // Request must stay up until ack; remember the target.
                        pc_pending_d = redirect_pc;
                        ir_d         = NOP_INSTR;
                        if_valid_d   = 1'b0;
                        state_d      = S_DROP;
                    end else if (!stall) begin
                        if_valid_d   = 1'b0;
                    end
                end
            end

            S_DROP: begin
                ir_d       = NOP_INSTR;
                if_valid_d = 1'b0;
                if (redirect) begin
                    pc_pending_d = redirect_pc;
                end
                if (imem_ack) begin
                    // The newest redirect target wins, even on the ack cycle.
                    pc_d    = redirect ? redirect_pc : pc_pending_q;
                    state_d = S_WAIT;
                end
            end

            S_FULL: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    pc_d       = redirect_pc;
                    ir_d       = NOP_INSTR;
                    if_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end else if (!stall) begin
                    skid_unload = 1'b1;
                    ir_d        = skid_data;
                    pc_1_d      = skid_pc + 32'd1;
                    if_valid_d  = 1'b1;
                    state_d     = S_WAIT;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Controller state and the registered decode-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT;
            pc_q         <= RESET_PC;
            pc_pending_q <= RESET_PC;
            ir_q         <= NOP_INSTR;
            pc_1_q       <= 32'd0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_pending_q <= pc_pending_d;
            ir_q         <= ir_d;
            pc_1_q       <= pc_1_d;
            if_valid_q   <= if_valid_d;
        end
    end

    // No request while a fetched word is parked; otherwise the PC is on the bus.
    assign imem_req  = ~skid_full;
    assign imem_addr = pc_q;
    assign IR        = ir_q;
    assign PC_1      = pc_1_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a transaction-level fetch model
// and a programmable-latency instruction memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IR, PC_1;
    logic        if_valid;

    // Second instance exercising the top-of-address-space reset PC.
    logic        stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic        imem_req2, imem_ack2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] IR2, PC_1_2;
    logic        if_valid2;

    int vectors     = 0;
    int miscompares = 0;

    int mem_lat = 0;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IR          (IR),
        .PC_1        (PC_1),
        .if_valid    (if_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_ack    (imem_ack2),
        .imem_rdata  (imem_rdata2),
        .IR          (IR2),
        .PC_1        (PC_1_2),
        .if_valid    (if_valid2)
    );

    // Zero-wait memory for the second instance.
    assign stall2       = 1'b0;
    assign redirect2    = 1'b0;
    assign redirect_pc2 = 32'd0;
    assign imem_ack2    = imem_req2;
    assign imem_rdata2  = mem_word(imem_addr2);

    // Fetch model: next address, at most one fetched-but-undelivered word,
    // and whether the outstanding fetch is stale after a redirect.
    logic [31:0] m_pc, m_target, m_buf_addr, m_ir, m_pc1;
    bit          m_buf, m_squash, m_valid, m_ir_known;

    task automatic model_reset();
        m_pc       = 32'd0;
        m_target   = 32'd0;
        m_buf_addr = 32'd0;
        m_buf      = 1'b0;
        m_squash   = 1'b0;
        m_ir       = 32'd0;
        m_ir_known = 1'b1;
        m_pc1      = 32'd0;
        m_valid    = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] a);
        m_ir       = mem_word(a);
        m_ir_known = 1'b1;
        m_pc1      = a + 32'd1;
        m_valid    = 1'b1;
    endtask

    task automatic model_step();
        if (redirect) begin
            m_ir       = 32'd0;
            m_ir_known = 1'b1;
            m_valid    = 1'b0;
            if (m_buf || imem_ack) begin
                m_buf    = 1'b0;
                m_squash = 1'b0;
                m_pc     = redirect_pc;
            end else begin
                m_squash = 1'b1;
                m_target = redirect_pc;
            end
        end else if (m_squash) begin
            if (imem_ack) begin
                m_squash = 1'b0;
                m_pc     = m_target;
            end
        end else if (m_buf) begin
            if (!stall) begin
                deliver(m_buf_addr);
                m_buf = 1'b0;
            end
        end else if (imem_ack) begin
            if (stall) begin
                m_buf      = 1'b1;
                m_buf_addr = m_pc;
            end else begin
                deliver(m_pc);
            end
            m_pc = m_pc + 32'd1;
        end else if (!stall) begin
            m_valid    = 1'b0;
            m_ir_known = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("imem_req", {31'd0, imem_req}, {31'd0, !m_buf});
        if (!m_buf) check("imem_addr", imem_addr, m_pc);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (m_ir_known) check("IR", IR, m_ir);
        check("PC_1", PC_1, m_pc1);
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = imem_req && (mem_cnt >= mem_lat);
        imem_rdata  = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        compare();
        model_step();
        if (imem_req) mem_cnt = imem_ack ? 0 : mem_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst IR", IR, 32'h0000_0000);
        check("rst PC_1", PC_1, 32'd0);
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst2 imem_addr", imem_addr2, 32'hFFFF_FFFF);
        rst_n = 1'b1;

        // Zero-wait streaming, plus wrap from FFFF_FFFF on the second instance
        tick(0, 0, 0);
        check("s0 IR", IR, 32'hA000_0000);
        check("s0 PC_1", PC_1, 32'd1);
        check("s0 valid", {31'd0, if_valid}, 32'd1);
        check("w0 IR", IR2, 32'h9FFF_FFFF);
        check("w0 PC_1", PC_1_2, 32'd0);
        check("w0 addr", imem_addr2, 32'd0);
        tick(0, 0, 0);
        check("s1 IR", IR, 32'hA000_0001);
        check("s1 PC_1", PC_1, 32'd2);
        check("w1 IR", IR2, 32'hA000_0000);
        check("w1 PC_1", PC_1_2, 32'd1);
        tick(0, 0, 0);
        check("s2 IR", IR, 32'hA000_0002);
        check("s2 PC_1", PC_1, 32'd3);

        // Stall on the ack cycle for address 5
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check("st IR", IR, 32'hA000_0004);
        check("st PC_1", PC_1, 32'd5);
        check("st req", {31'd0, imem_req}, 32'd0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        check("st hold IR", IR, 32'hA000_0004);
        tick(0, 0, 0);
        check("unst IR", IR, 32'hA000_0005);
        check("unst PC_1", PC_1, 32'd6);
        check("unst addr", imem_addr, 32'd6);
        tick(0, 0, 0);
        check("after IR", IR, 32'hA000_0006);
        check("after PC_1", PC_1, 32'd7);

        // Redirect during a 3-cycle fetch of address 8
        mem_lat = 3;
        repeat (4) tick(0, 0, 0);
        check("lat IR", IR, 32'hA000_0007);
        tick(0, 1, 32'h100);
        check("drop addr", imem_addr, 32'd8);
        check("drop IR", IR, 32'h0000_0000);
        tick(0, 0, 0);
        check("drop addr2", imem_addr, 32'd8);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("redir addr", imem_addr, 32'h100);
        check("redir valid", {31'd0, if_valid}, 32'd0);
        repeat (4) tick(0, 0, 0);
        check("redir IR", IR, 32'hA000_0100);
        check("redir PC_1", PC_1, 32'h101);

        // Redirect with stall while the skid is full
        mem_lat = 0;
        tick(1, 0, 0);
        check("full req", {31'd0, imem_req}, 32'd0);
        tick(1, 1, 32'h200);
        check("fl IR", IR, 32'h0000_0000);
        check("fl valid", {31'd0, if_valid}, 32'd0);
        check("fl addr", imem_addr, 32'h200);
        tick(0, 0, 0);
        check("fl next IR", IR, 32'hA000_0200);

        // Redirect on a zero-wait ack cycle discards the data
        tick(0, 1, 32'h300);
        check("ackr IR", IR, 32'h0000_0000);
        check("ackr addr", imem_addr, 32'h300);
        tick(0, 0, 0);
        check("ackr next IR", IR, 32'hA000_0300);

        // Second redirect while dropping overwrites the pending target
        mem_lat = 2;
        tick(0, 1, 32'h400);
        tick(0, 1, 32'h500);
        tick(0, 0, 0);
        check("dd addr", imem_addr, 32'h500);
        mem_lat = 0;
        tick(0, 0, 0);
        check("dd IR", IR, 32'hA000_0500);
        check("dd PC_1", PC_1, 32'h501);

        // Reset pulsed while a stale fetch is outstanding
        mem_lat = 3;
        tick(0, 0, 0);
        tick(0, 1, 32'h600);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        check("mrst IR", IR, 32'h0000_0000);
        check("mrst PC_1", PC_1, 32'd0);
        check("mrst valid", {31'd0, if_valid}, 32'd0);
        check("mrst addr", imem_addr, 32'd0);
        model_reset();
        mem_cnt = 0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        mem_lat  = 0;
        tick(0, 0, 0);
        check("post IR", IR, 32'hA000_0000);
        check("post PC_1", PC_1, 32'd1);
        tick(0, 0, 0);
        tick(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Pipeline stage directly upstream of the decode/operand-fetch stage.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Drives the registered IR and PC_1 that decode consumes.
- Absorbs decode stalls with a one-entry skid buffer and flushes on branch/jump redirect from the downstream branch logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value fetched first after reset
NOP_INSTR, 32'h0000_0000, encoding placed in IR on reset and on flush

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  decode hazard; hold IR/PC_1/if_valid
redirect  in  1  taken branch/jump; flush and reload PC
redirect_pc  in  32  target address, valid when redirect=1
imem_req  out  1  fetch request
imem_addr  out  32  word address of request
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
IR  out  32  instruction register to decode
PC_1  out  32  address of IR instruction + 1
if_valid  out  1  IR holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, IR=NOP_INSTR, PC_1=0, if_valid=0.
  - Skid buffer empty; state=S_WAIT.
  - An outstanding memory response is forgotten.
- Word addressing: PC increments by 1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
- Request rule: once imem_req=1, imem_addr stays stable until the imem_ack cycle. A request is never withdrawn before ack, except by reset.
- S_WAIT: imem_req=1, imem_addr=PC. On an imem_ack cycle, with priority redirect > stall > normal:
  - redirect: discard rdata; PC<=redirect_pc; IR<=NOP_INSTR; if_valid<=0; stay S_WAIT.
  - stall: skid<=rdata, skid_pc<=PC; PC<=PC+1; go S_FULL; IR/PC_1/if_valid unchanged.
  - normal: IR<=rdata; PC_1<=PC+1; PC<=PC+1; if_valid<=1; stay S_WAIT.
- S_WAIT with no ack:
  - redirect: PC_pending<=redirect_pc; IR<=NOP_INSTR; if_valid<=0; go S_DROP.
  - stall only: hold outputs.
  - neither stall nor redirect: if_valid<=0 (bubble). IR holds the prior value, which is don't-care while if_valid=0.
- S_DROP: imem_req=1 with the old address held.
  - On ack: discard data; PC<=PC_pending; go S_WAIT.
  - A further redirect while in S_DROP overwrites PC_pending. IR stays NOP, if_valid=0.
- S_FULL: imem_req=0.
  - redirect: empty skid; PC<=redirect_pc; IR<=NOP; if_valid<=0; go S_WAIT.
  - else if !stall: IR<=skid; PC_1<=skid_pc+1; if_valid<=1; go S_WAIT.
  - else: hold.
- Flush overrides stall: redirect always forces IR=NOP_INSTR, if_valid=0 at the next edge.
- Latency: ack in cycle n puts the instruction on IR after edge n. With zero-wait memory (ack in the same cycle as req), throughput is one instruction per cycle.
- No instruction is lost or duplicated across any stall/redirect/ack combination.

Decomposition:
- Shared package risc_pkg: NOP_INSTR, RESET_PC default, and enum if_state_t {S_WAIT, S_DROP, S_FULL}. Decode reuses NOP_INSTR.
- One natural sub-module, if_skid_buf: a 32-bit data plus 32-bit pc register with a full flag, and load/unload/clear controls.

Test Plan:
- Reset release, zero-wait memory returning mem[a]=32'hA000_0000+a -> IR sequence A000_0000, A000_0001, A000_0002 on consecutive cycles; PC_1 = 1, 2, 3; if_valid=1 from the first ack edge.
- stall high 3 cycles, asserted on an ack cycle for addr 5 -> IR/PC_1 frozen at addr 4 / 5; imem_req=0 while the skid is full. After release, IR=mem[5], PC_1=6, then mem[6] next; no skip or duplicate.
- redirect to 32'h100 while a 3-cycle-latency fetch of addr 8 is outstanding -> imem_addr held at 8 until ack. Data for 8 is discarded, next imem_addr=32'h100, if_valid=0 throughout, then IR=mem[0x100] with PC_1=0x101.
- redirect and stall together with skid full -> skid cleared, IR=NOP_INSTR, if_valid=0, next fetch from redirect_pc.
- RESET_PC=32'hFFFF_FFFF -> first fetch FFFF_FFFF with PC_1=0, next fetch addr 0.
- rst_n pulsed low mid-wait (between req and ack) -> outputs immediately NOP/0/0. After release, a stale ack is not taken as valid data unless it follows the new req for RESET_PC.
